// File: rtl/mmio_key_capture_if.sv
// CPU memory bus as seen by the key-capture peripheral.
// read_data is tri-stated by the slave whenever it does not decode a read.
interface mmio_key_capture_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;

  modport master (output mem_cmd, output mem_addr, output write_data, input read_data);
  modport slave  (input mem_cmd, input mem_addr, input write_data, output read_data);
endinterface

// File: rtl/mmio_key_capture.sv
// Push-button capture peripheral: synchronises and debounces active-low keys,
// latches sticky W1C press/overflow flags and counts presses.
module mmio_key_capture #(
  parameter int         NKEYS     = 2,
  parameter int         DEB_CYC   = 4,
  parameter logic [8:0] STAT_ADDR = 9'h148,
  parameter logic [8:0] LVL_ADDR  = 9'h149,
  parameter logic [8:0] CNT_ADDR  = 9'h14A
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NKEYS-1:0]   key_n,
  mmio_key_capture_if.slave  bus,
  output logic [NKEYS-1:0]   key_level
);

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

  logic [NKEYS-1:0] s1, s2, lvl, lvl_nxt, rise;
  logic [NKEYS-1:0] pending, pending_nxt, overflow, overflow_nxt;
  logic [NKEYS-1:0] clr_pend, clr_ovf;
  logic [3:0]       deb_cnt [NKEYS];
  logic [3:0]       deb_nxt [NKEYS];
  logic [7:0]       press_cnt, press_cnt_nxt, rise_cnt;
  logic             rd_hit, wr_stat, wr_cnt;
  logic [15:0]      rd_mux;

  assign wr_stat = (bus.mem_cmd == MWRITE) && (bus.mem_addr == STAT_ADDR);
  assign wr_cnt  = (bus.mem_cmd == MWRITE) && (bus.mem_addr == CNT_ADDR);
  assign rd_hit  = (bus.mem_cmd == MREAD) &&
                   ((bus.mem_addr == STAT_ADDR) || (bus.mem_addr == LVL_ADDR) ||
                    (bus.mem_addr == CNT_ADDR));

  always_comb begin
    rise     = '0;
    lvl_nxt  = lvl;
    rise_cnt = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      deb_nxt[i] = '0;
      if (s2[i] != lvl[i]) begin
        if (deb_cnt[i] == DEB_LAST) begin
          lvl_nxt[i] = s2[i];
          rise[i]    = s2[i];
        end else begin
          deb_nxt[i] = deb_cnt[i] + 4'd1;
        end
      end
      rise_cnt = rise_cnt + {7'b0, rise[i]};
    end

    clr_pend = wr_stat ? bus.write_data[NKEYS-1:0]     : '0;
    clr_ovf  = wr_stat ? bus.write_data[8 +: NKEYS]    : '0;
    // A rise beats a same-cycle clear; overflow only when the old flag survives.
    pending_nxt   = (pending & ~clr_pend) | rise;
    overflow_nxt  = (overflow & ~clr_ovf) | (rise & pending & ~clr_pend);
    press_cnt_nxt = wr_cnt ? bus.write_data[7:0] : press_cnt + rise_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      lvl       <= '0;
      pending   <= '0;
      overflow  <= '0;
      press_cnt <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) deb_cnt[i] <= '0;
    end else begin
      s1        <= ~key_n;
      s2        <= s1;
      lvl       <= lvl_nxt;
      pending   <= pending_nxt;
      overflow  <= overflow_nxt;
      press_cnt <= press_cnt_nxt;
      for (int unsigned i = 0; i < NKEYS; i++) deb_cnt[i] <= deb_nxt[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.mem_addr == STAT_ADDR) begin
      rd_mux[NKEYS-1:0]  = pending;
      rd_mux[8 +: NKEYS] = overflow;
    end else if (bus.mem_addr == LVL_ADDR) begin
      rd_mux[NKEYS-1:0] = lvl;
    end else if (bus.mem_addr == CNT_ADDR) begin
      rd_mux[7:0] = press_cnt;
    end
  end

  assign bus.read_data = rd_hit ? rd_mux : 'z;
  assign key_level     = lvl;

endmodule
